debug_unit_ctrl: RTL

Command sequencer between the UART byte link and the MIPS pipeline inside the top-level. Decodes single-byte host commands; loads the instruction memory byte by byte; gates pipeline execution (continuous or single-step); serialises register bank, data memory and PC back to the host over the transmitter handshake. Exposes its one-hot state and the halt flag for board LEDs.

---
 rtl/debug_pkg.sv | 58 +++++
 rtl/debug_word_serializer.sv | 80 ++++++++
 rtl/debug_unit_ctrl.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/debug_pkg.sv
// -----------------------------------------------------------------------------
// debug_pkg
// Shared constants for the debug unit command sequencer:
//   - datapath widths (UART byte, CPU word, read address, IM byte address)
//   - host command codes
//   - one-hot FSM state encodings (bit index == state number)
//   - dump lengths (words per dump, bytes per word)
// Optional feature macro: DEBUG_STEP_EN (step-mode states/commands).
// -----------------------------------------------------------------------------
package debug_pkg;

  localparam int unsigned BYTE     = 8;
  localparam int unsigned DWORD    = 32;
  localparam int unsigned ADDR     = 5;
  localparam int unsigned NB_ST    = 10;
  localparam int unsigned IM_BYTES = 256;
  localparam int unsigned IM_AW    = 8;

  // Host command codes
  localparam logic [BYTE-1:0] CMD_LOAD      = 8'd1;
  localparam logic [BYTE-1:0] CMD_RUN       = 8'd2;
  localparam logic [BYTE-1:0] CMD_STEP_MODE = 8'd3;
  localparam logic [BYTE-1:0] CMD_DUMP_BR   = 8'd4;
  localparam logic [BYTE-1:0] CMD_DUMP_DM   = 8'd5;
  localparam logic [BYTE-1:0] CMD_DUMP_PC   = 8'd6;
  localparam logic [BYTE-1:0] CMD_STEP      = 8'd7;

  // One-hot states; these encodings are visible on the board LEDs.
  localparam logic [NB_ST-1:0] ST_IDLE      = 10'b00_0000_0001;
  localparam logic [NB_ST-1:0] ST_LOAD      = 10'b00_0000_0010;
  localparam logic [NB_ST-1:0] ST_READY     = 10'b00_0000_0100;
  localparam logic [NB_ST-1:0] ST_RUN       = 10'b00_0000_1000;
  localparam logic [NB_ST-1:0] ST_STEP_WAIT = 10'b00_0001_0000;
  localparam logic [NB_ST-1:0] ST_STEP      = 10'b00_0010_0000;
  localparam logic [NB_ST-1:0] ST_DUMP_BR   = 10'b00_0100_0000;
  localparam logic [NB_ST-1:0] ST_DUMP_DM   = 10'b00_1000_0000;
  localparam logic [NB_ST-1:0] ST_DUMP_PC   = 10'b01_0000_0000;
  localparam logic [NB_ST-1:0] ST_TX_WAIT   = 10'b10_0000_0000;

  // Dump lengths
  localparam int unsigned BR_WORDS       = 32;
  localparam int unsigned DM_WORDS       = 32;
  localparam int unsigned PC_WORDS       = 1;
  localparam int unsigned BYTES_PER_WORD = 4;

  function automatic logic is_dump_cmd(input logic [BYTE-1:0] cmd);
    return (cmd == CMD_DUMP_BR) || (cmd == CMD_DUMP_DM) || (cmd == CMD_DUMP_PC);
  endfunction

  function automatic logic [NB_ST-1:0] dump_state(input logic [BYTE-1:0] cmd);
    case (cmd)
      CMD_DUMP_BR: return ST_DUMP_BR;
      CMD_DUMP_DM: return ST_DUMP_DM;
      default:     return ST_DUMP_PC;
    endcase
  endfunction

endpackage

// File: rtl/debug_word_serializer.sv
// -----------------------------------------------------------------------------
// debug_word_serializer
// Sends one DWORD as BYTES_PER_WORD bytes, least-significant first, over the
// UART transmitter handshake.
//   clk_i       system clock
//   rst_i       synchronous active-high reset
//   start_i     one-cycle pulse: capture word_i and request byte 0
//   word_i      word to send
//   tx_done_i   one-cycle pulse: transmitter finished the current byte
//   tx_start_o  one-cycle transmit request (registered)
//   tx_data_o   byte to transmit, held until the next tx_start_o
//   done_o      one-cycle pulse with the tx_done_i of the last byte
// -----------------------------------------------------------------------------
module debug_word_serializer
  import debug_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [DWORD-1:0] word_i,
  input  logic             tx_done_i,
  output logic             tx_start_o,
  output logic [BYTE-1:0]  tx_data_o,
  output logic             done_o
);

  localparam logic [1:0] LastIdx = 2'(BYTES_PER_WORD - 1);

  logic [DWORD-1:0] word_q, word_d;
  logic [1:0]       idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             start_q, start_d;
  logic [BYTE-1:0]  data_q, data_d;

  always_comb begin
    word_d  = word_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    start_d = 1'b0;
    data_d  = data_q;
    if (start_i) begin
      word_d  = word_i;
      data_d  = word_i[BYTE-1:0];
      idx_d   = '0;
      busy_d  = 1'b1;
      start_d = 1'b1;
    end else if (busy_q && tx_done_i) begin
      if (idx_q == LastIdx) begin
        busy_d = 1'b0;
      end else begin
        // Shift register: the next byte always sits in bits [15:8].
        idx_d   = idx_q + 2'd1;
        data_d  = word_q[2*BYTE-1:BYTE];
        word_d  = {{BYTE{1'b0}}, word_q[DWORD-1:BYTE]};
        start_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      word_q  <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      data_q  <= '0;
    end else begin
      word_q  <= word_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      start_q <= start_d;
      data_q  <= data_d;
    end
  end

  assign tx_start_o = start_q;
  assign tx_data_o  = data_q;
  assign done_o     = busy_q & tx_done_i & (idx_q == LastIdx);

endmodule

// File: rtl/debug_unit_ctrl.sv
// -----------------------------------------------------------------------------
// debug_unit_ctrl
// Command sequencer between the UART byte link and the MIPS pipeline.
// Decodes one-byte host commands, loads instruction memory byte by byte,
// gates pipeline execution (continuous or single-step) and streams register
// bank, data memory and PC back to the host.
// Optional feature macro: DEBUG_STEP_EN enables STEP_WAIT/STEP and commands
// 3/7; without it those commands are ignored and o_state[5:4] stay 0.
// Ports:
//   i_clock, i_reset            clock, synchronous active-high reset
//   i_rx_done, i_rx_data        received byte strobe / data
//   i_tx_done                   transmitter finished last byte
//   i_cpu_halt                  pipeline retired HALT
//   i_br_data, i_dm_data, i_pc  read data for o_rd_addr, current PC
//   o_tx_data, o_tx_start       byte to send / one-cycle send request
//   o_im_we/o_im_addr/o_im_data instruction-memory byte write
//   o_cpu_en, o_cpu_clear       pipeline enable / one-cycle clear
//   o_rd_addr                   register bank / data memory word address
//   o_hlt, o_state              halt flag and one-hot state (LEDs)
// -----------------------------------------------------------------------------
module debug_unit_ctrl
  import debug_pkg::*;
(
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_rx_done,
  input  logic [BYTE-1:0]   i_rx_data,
  input  logic              i_tx_done,
  input  logic              i_cpu_halt,
  input  logic [DWORD-1:0]  i_br_data,
  input  logic [DWORD-1:0]  i_dm_data,
  input  logic [DWORD-1:0]  i_pc,
  output logic [BYTE-1:0]   o_tx_data,
  output logic              o_tx_start,
  output logic              o_im_we,
  output logic [IM_AW-1:0]  o_im_addr,
  output logic [BYTE-1:0]   o_im_data,
  output logic              o_cpu_en,
  output logic              o_cpu_clear,
  output logic [ADDR-1:0]   o_rd_addr,
  output logic              o_hlt,
  output logic [NB_ST-1:0]  o_state
);

  logic [NB_ST-1:0] state_q, state_d;
  logic [NB_ST-1:0] ret_q, ret_d;       // state resumed after a dump
  logic [NB_ST-1:0] dump_q, dump_d;     // dump in progress (BR/DM/PC)
  logic             phase_q, phase_d;   // 0: address out, 1: capture word
  logic [ADDR-1:0]  rd_addr_q, rd_addr_d;
  logic [IM_AW-1:0] im_cnt_q, im_cnt_d;
  logic             im_we_q, im_we_d;
  logic [IM_AW-1:0] im_addr_q, im_addr_d;
  logic [BYTE-1:0]  im_data_q, im_data_d;
  logic             clear_q, clear_d;
  logic             hlt_q, hlt_d;

  logic             go_load;
  logic             go_dump;
  logic             ser_start;
  logic             ser_done;
  logic             ser_tx_done;
  logic [DWORD-1:0] ser_word;
  logic [ADDR-1:0]  last_addr;

  // Word source and last word address for the active dump
  always_comb begin
    unique case (dump_q)
      ST_DUMP_BR: begin
        ser_word  = i_br_data;
        last_addr = ADDR'(BR_WORDS - 1);
      end
      ST_DUMP_DM: begin
        ser_word  = i_dm_data;
        last_addr = ADDR'(DM_WORDS - 1);
      end
      default: begin
        ser_word  = i_pc;
        last_addr = ADDR'(PC_WORDS - 1);
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    dump_d    = dump_q;
    phase_d   = phase_q;
    rd_addr_d = rd_addr_q;
    im_cnt_d  = im_cnt_q;
    im_we_d   = 1'b0;
    im_addr_d = im_addr_q;
    im_data_d = im_data_q;
    clear_d   = 1'b0;
    hlt_d     = hlt_q;
    ser_start = 1'b0;
    go_load   = 1'b0;
    go_dump   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (i_rx_done && i_rx_data == CMD_LOAD) go_load = 1'b1;
      end

      ST_LOAD: begin
        if (i_rx_done) begin
          im_we_d   = 1'b1;
          im_addr_d = im_cnt_q;
          im_data_d = i_rx_data;
          im_cnt_d  = im_cnt_q + 1'b1;
          if (im_cnt_q == IM_AW'(IM_BYTES - 1)) state_d = ST_READY;
        end
      end

      ST_READY: begin
        if (i_rx_done) begin
          if (i_rx_data == CMD_LOAD) begin
            go_load = 1'b1;
          end else if (i_rx_data == CMD_RUN) begin
            // A halted program must be reloaded before it can run again.
            if (!hlt_q) state_d = ST_RUN;
`ifdef DEBUG_STEP_EN
          end else if (i_rx_data == CMD_STEP_MODE) begin
            state_d = ST_STEP_WAIT;
`endif
          end else if (is_dump_cmd(i_rx_data)) begin
            go_dump = 1'b1;
          end
        end
      end

      ST_RUN: begin
        // Halt has priority; any byte arriving while running is dropped.
        if (i_cpu_halt) begin
          hlt_d   = 1'b1;
          state_d = ST_READY;
        end
      end

`ifdef DEBUG_STEP_EN
      ST_STEP_WAIT: begin
        if (i_rx_done) begin
          if (i_rx_data == CMD_LOAD) begin
            go_load = 1'b1;
          end else if (i_rx_data == CMD_STEP) begin
            if (!hlt_q) state_d = ST_STEP;
          end else if (is_dump_cmd(i_rx_data)) begin
            go_dump = 1'b1;
          end
        end
      end

      ST_STEP: begin
        state_d = ST_STEP_WAIT;
        if (i_cpu_halt) hlt_d = 1'b1;
      end
`endif

      ST_DUMP_BR, ST_DUMP_DM, ST_DUMP_PC: begin
        // Two-cycle fetch lets the read ports be combinational or registered.
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d   = 1'b0;
          ser_start = 1'b1;
          state_d   = ST_TX_WAIT;
        end
      end

      ST_TX_WAIT: begin
        if (ser_done) begin
          if (rd_addr_q == last_addr) begin
            state_d = ret_q;
          end else begin
            rd_addr_d = rd_addr_q + 1'b1;
            state_d   = dump_q;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (go_load) begin
      state_d  = ST_LOAD;
      clear_d  = 1'b1;
      hlt_d    = 1'b0;
      im_cnt_d = '0;
    end
    if (go_dump) begin
      state_d   = dump_state(i_rx_data);
      dump_d    = dump_state(i_rx_data);
      ret_d     = state_q;
      rd_addr_d = '0;
      phase_d   = 1'b0;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      ret_q     <= ST_READY;
      dump_q    <= ST_DUMP_BR;
      phase_q   <= 1'b0;
      rd_addr_q <= '0;
      im_cnt_q  <= '0;
      im_we_q   <= 1'b0;
      im_addr_q <= '0;
      im_data_q <= '0;
      clear_q   <= 1'b0;
      hlt_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      dump_q    <= dump_d;
      phase_q   <= phase_d;
      rd_addr_q <= rd_addr_d;
      im_cnt_q  <= im_cnt_d;
      im_we_q   <= im_we_d;
      im_addr_q <= im_addr_d;
      im_data_q <= im_data_d;
      clear_q   <= clear_d;
      hlt_q     <= hlt_d;
    end
  end

  // A done pulse overlapping our own start request cannot belong to it.
  assign ser_tx_done = i_tx_done & (state_q == ST_TX_WAIT) & ~o_tx_start;

  debug_word_serializer u_serializer (
    .clk_i      (i_clock),
    .rst_i      (i_reset),
    .start_i    (ser_start),
    .word_i     (ser_word),
    .tx_done_i  (ser_tx_done),
    .tx_start_o (o_tx_start),
    .tx_data_o  (o_tx_data),
    .done_o     (ser_done)
  );

  // Enable drops in the same cycle the halt is seen.
  assign o_cpu_en    = ((state_q == ST_RUN) & ~i_cpu_halt) | (state_q == ST_STEP);
  assign o_cpu_clear = clear_q;
  assign o_im_we     = im_we_q;
  assign o_im_addr   = im_addr_q;
  assign o_im_data   = im_data_q;
  assign o_rd_addr   = rd_addr_q;
  assign o_hlt       = hlt_q;

`ifdef DEBUG_STEP_EN
  assign o_state = state_q;
`else
  assign o_state = state_q & ~(ST_STEP_WAIT | ST_STEP);
`endif

endmodule
